// File: rtl/bcd_cnt_pkg.sv
// Shared types and constant helpers for the cascadable BCD counter.
// Digit width, a fixed-width BCD vector type and BCD conversion/validation functions.
package bcd_cnt_pkg;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 8;
  localparam int VEC_W      = BCD_W * MAX_DIGITS;

  typedef logic [BCD_W-1:0] bcd_digit_t;
  typedef logic [VEC_W-1:0] bcd_vec_t;

  function automatic bcd_vec_t to_bcd(input int value);
    bcd_vec_t r;
    int       v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      r[i*BCD_W +: BCD_W] = BCD_W'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input bcd_vec_t vec);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (vec[i*BCD_W +: BCD_W] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with clear, preset load and ripple increment/decrement.
// Priority: clr > ld > inc_in > dec_in > hold; nine/zero feed the ripple chain.
module bcd_digit
  import bcd_cnt_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       ld,
  input  bcd_digit_t ld_val,
  input  logic       inc_in,
  input  logic       dec_in,
  output bcd_digit_t digit,
  output logic       nine,
  output logic       zero
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = 4'd0;
    end else if (ld) begin
      digit_d = ld_val;
    end else if (inc_in) begin
      digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    end else if (dec_in) begin
      digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
    end else begin
      digit_d = digit_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign nine  = (digit_q == 4'd9);
  assign zero  = (digit_q == 4'd0);

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit cascadable BCD counter with programmable modulus, validated preset load and carry_out.
// Define BCD_CNT_UPDOWN_EN to add the dir port and down counting with borrow.
module bcd_counter_n
  import bcd_cnt_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 100
) (
  input  logic                clk_100Hz,
  input  logic                rst_n,
  input  logic                clr_flag,
  input  logic                en,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
`ifdef BCD_CNT_UPDOWN_EN
  input  logic                dir,
`endif
  output logic [4*DIGITS-1:0] cnt,
  output logic                tc,
  output logic                carry_out,
  output logic                load_err
);

  localparam int             CW      = BCD_W * DIGITS;
  localparam bcd_vec_t       MAX_VEC = to_bcd(MODULUS - 1);
  localparam logic [CW-1:0]  MAX_BCD = MAX_VEC[CW-1:0];

  generate
    if (DIGITS < 1 || DIGITS > MAX_DIGITS || MODULUS < 2 || MODULUS > 10**DIGITS) begin : g_param_err
      $error("bcd_counter_n: illegal DIGITS=%0d / MODULUS=%0d", DIGITS, MODULUS);
    end
  endgenerate

  logic              up_s;
  logic              load_ok_s;
  logic              step_s;
  logic              wrap_s;
  logic              digit_ld_s;
  logic [CW-1:0]     digit_ld_val_s;
  logic [DIGITS-1:0] inc_s;
  logic [DIGITS-1:0] dec_s;
  logic [DIGITS-1:0] nine_s;
  logic [DIGITS-1:0] zero_s;
  logic              unused_top_nine_s;
  logic              load_err_q;
  logic              load_err_d;

`ifdef BCD_CNT_UPDOWN_EN
  assign up_s = dir;
`else
  assign up_s = 1'b1;
`endif

  // BCD vectors of equal width order the same way as their numeric values.
  assign load_ok_s  = bcd_valid(bcd_vec_t'(load_val)) && (load_val <= MAX_BCD);
  assign tc         = up_s ? (cnt == MAX_BCD) : (&zero_s);
  assign carry_out  = tc & en;
  assign step_s     = en & ~clr_flag & ~load;
  assign wrap_s     = step_s & tc;

  // Full-value wrap is applied as a load so a short modulus never passes through e.g. 60.
  assign digit_ld_s     = (load & load_ok_s) | wrap_s;
  assign digit_ld_val_s = load ? load_val : (up_s ? {CW{1'b0}} : MAX_BCD);

  always_comb begin
    inc_s    = {DIGITS{1'b0}};
    dec_s    = {DIGITS{1'b0}};
    inc_s[0] = step_s & up_s;
    dec_s[0] = step_s & ~up_s;
    for (int i = 1; i < DIGITS; i++) begin
      inc_s[i] = inc_s[i-1] & nine_s[i-1];
      dec_s[i] = dec_s[i-1] & zero_s[i-1];
    end
  end

  assign unused_top_nine_s = nine_s[DIGITS-1];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk_100Hz),
      .rst_n  (rst_n),
      .clr    (clr_flag),
      .ld     (digit_ld_s),
      .ld_val (digit_ld_val_s[g*BCD_W +: BCD_W]),
      .inc_in (inc_s[g]),
      .dec_in (dec_s[g]),
      .digit  (cnt[g*BCD_W +: BCD_W]),
      .nine   (nine_s[g]),
      .zero   (zero_s[g])
    );
  end

  assign load_err_d = load & ~clr_flag & ~load_ok_s;

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  assign load_err = load_err_q;

endmodule
